// File: rtl/clb_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader_if
//   Bundles the configuration loader's serial input, its CLB write port and
//   its status flags.
//
//   Signals:
//     PROG      synchronous restart request from the configuration controller
//     DIN       serial configuration data, MSB first
//     DIN_EN    DIN qualifier; DIN is sampled only when high
//     cfg_data  assembled CFG_W-bit configuration word for one CLB
//     cfg_addr  target CLB index (0-based frame number)
//     cfg_we    one-cycle write strobe for cfg_data/cfg_addr
//     busy      high from preamble lock until done or error
//     done      sticky: all frames loaded without error
//     err       sticky: framing, parity or count error
//
//   Modports:
//     master  configuration controller side (drives the stream, sees the writes)
//     slave   loader side
// ---------------------------------------------------------------------------
interface clb_cfg_loader_if #(
    parameter int CFG_W  = 37,
    parameter int ADDR_W = 8
);
    logic              PROG;
    logic              DIN;
    logic              DIN_EN;
    logic [CFG_W-1:0]  cfg_data;
    logic [ADDR_W-1:0] cfg_addr;
    logic              cfg_we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output PROG, DIN, DIN_EN,
        input  cfg_data, cfg_addr, cfg_we, busy, done, err
    );

    modport slave (
        input  PROG, DIN, DIN_EN,
        output cfg_data, cfg_addr, cfg_we, busy, done, err
    );
endinterface

// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader
//   Serial configuration loader feeding the CLB array. Hunts for the 8-bit
//   preamble 1111_0010, reads an ADDR_W-bit frame count N, then deframes N
//   frames of the form
//       idle 1s, start 0, CFG_W data bits (MSB first), even parity, stop 1
//   and writes each good frame's word to CLB <frame index> with a one-cycle
//   cfg_we strobe.
//
//   cfg_data field map (CFG_W = 37):
//     [36:35] mux2select  [34:33] mux3select  [32:31] mux4select
//     [30:29] mux5select  [28:27] mux6select  [26:11] mem[15:0]
//     [10:9]  comboption  [8:3]   o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
//     [2:1]   DQmux1, DQmux2  [0] floporlatch
//
//   Ports:
//     K      clock, all state updates on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    clb_cfg_loader_if.slave (serial input, write port, status)
// ---------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int CFG_W  = 37,
    parameter int ADDR_W = 8
) (
    input  logic                   K,
    input  logic                   rst_n,
    clb_cfg_loader_if.slave        bus
);

    localparam logic [7:0] PREAMBLE = 8'b1111_0010;

    // One counter serves both the count byte and the data field.
    localparam int CNT_MAX = (CFG_W > ADDR_W) ? CFG_W : ADDR_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_COUNT_BIT = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LAST_DATA_BIT  = CNT_W'(CFG_W - 1);

    typedef enum logic [2:0] {
        HUNT,
        COUNT,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        ERROR
    } state_t;

    state_t            state;
    logic [7:0]        window;
    logic [ADDR_W-1:0] n_frames;
    logic [ADDR_W-1:0] frame_idx;
    logic [CFG_W-1:0]  data_sr;
    logic [CNT_W-1:0]  bit_cnt;

    // Next-window / next-count values so a match is seen on the same bit
    // that completes it.
    logic [7:0]        window_next;
    logic [ADDR_W-1:0] count_next;
    logic [ADDR_W-1:0] idx_plus1;

    assign window_next = {window[6:0], bus.DIN};
    assign count_next  = {n_frames[ADDR_W-2:0], bus.DIN};
    assign idx_plus1   = frame_idx + ADDR_W'(1);

    // NOTE: every register here is assigned with <= so all updates in one
    // K edge see the pre-edge values, exactly like the flops they model.
    always_ff @(posedge K or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            window       <= '0;
            n_frames     <= '0;
            frame_idx    <= '0;
            data_sr      <= '0;
            bit_cnt      <= '0;
            bus.cfg_data <= '0;
            bus.cfg_addr <= '0;
            bus.cfg_we   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            // Strobe defaults low so it is one K cycle wide whatever DIN_EN does.
            bus.cfg_we <= 1'b0;

            if (bus.PROG) begin
                // Restart wins over everything, including a strobe that would
                // have been raised this edge. cfg_data/cfg_addr are kept.
                state     <= HUNT;
                window    <= '0;
                n_frames  <= '0;
                frame_idx <= '0;
                data_sr   <= '0;
                bit_cnt   <= '0;
                bus.busy  <= 1'b0;
                bus.done  <= 1'b0;
                bus.err   <= 1'b0;
            end else if (bus.DIN_EN) begin
                case (state)
                    HUNT: begin
                        window <= window_next;
                        if (window_next == PREAMBLE) begin
                            state    <= COUNT;
                            bus.busy <= 1'b1;
                            bit_cnt  <= '0;
                        end
                    end

                    COUNT: begin
                        n_frames <= count_next;
                        if (bit_cnt == LAST_COUNT_BIT) begin
                            bit_cnt <= '0;
                            if (count_next == '0) begin
                                state    <= ERROR;
                                bus.err  <= 1'b1;
                                bus.busy <= 1'b0;
                            end else begin
                                state     <= START;
                                frame_idx <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end

                    START: begin
                        // DIN=1 is line idle; the first 0 is the start bit.
                        if (!bus.DIN) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end

                    DATA: begin
                        data_sr <= {data_sr[CFG_W-2:0], bus.DIN};
                        if (bit_cnt == LAST_DATA_BIT) begin
                            state   <= PARITY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end

                    PARITY: begin
                        // Even parity over data plus parity bit.
                        if ((^data_sr) ^ bus.DIN) begin
                            state    <= ERROR;
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= STOP;
                        end
                    end

                    STOP: begin
                        if (bus.DIN) begin
                            bus.cfg_data <= data_sr;
                            bus.cfg_addr <= frame_idx;
                            bus.cfg_we   <= 1'b1;
                            frame_idx    <= idx_plus1;
                            if (idx_plus1 == n_frames) begin
                                // done/busy change in the same cycle the last
                                // strobe is visible.
                                state    <= DONE;
                                bus.done <= 1'b1;
                                bus.busy <= 1'b0;
                            end else begin
                                state <= START;
                            end
                        end else begin
                            state    <= ERROR;
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                        end
                    end

                    // Absorbing until PROG or reset.
                    DONE, ERROR: ;

                    default: begin
                        state    <= ERROR;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_clb_cfg_loader
//   Directed bench for clb_cfg_loader: a table of frames for the multi-frame
//   load, plus hand-written sequences for parity, stop, preamble, zero-count,
//   PROG and mid-frame reset corner cases. A negedge monitor logs every
//   cfg_we cycle together with done/busy in that cycle.
// ---------------------------------------------------------------------------
module tb_clb_cfg_loader;

    localparam int CFG_W  = 37;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [CFG_W-1:0]  data;
        logic              done;
        logic              busy;
    } wr_t;

    typedef struct {
        logic [CFG_W-1:0]  data;      // frame payload
        int                idle;      // idle 1s before the start bit
        logic [ADDR_W-1:0] exp_addr;  // expected cfg_addr of the strobe
        logic              exp_done;  // expected done in the strobe cycle
    } vec_t;

    logic K;
    logic rst_n;

    clb_cfg_loader_if #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) bus ();

    clb_cfg_loader #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) dut (
        .K     (K),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        K = 1'b0;
        forever #5 K = ~K;
    end

    int  n_tests = 0;
    int  n_fail  = 0;
    int  en_mode = 0;
    wr_t wr_q[$];
    int  we_double = 0;
    logic prev_we = 1'b0;

    always @(negedge K) begin
        if (bus.cfg_we) begin
            wr_q.push_back('{addr: bus.cfg_addr, data: bus.cfg_data,
                             done: bus.done, busy: bus.busy});
            if (prev_we) we_double <= we_double + 1;
        end
        prev_we <= bus.cfg_we;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each qualified bit takes one K cycle; in en_mode a disabled cycle with
    // inverted (garbage) DIN precedes it.
    task automatic send_bit(input logic b);
        if (en_mode != 0) begin
            bus.DIN    = ~b;
            bus.DIN_EN = 1'b0;
            @(posedge K); #1;
        end
        bus.DIN    = b;
        bus.DIN_EN = 1'b1;
        @(posedge K); #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [CFG_W-1:0] d, input int idle,
                              input logic par_flip, input logic stop);
        repeat (idle) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = CFG_W - 1; i >= 0; i--) send_bit(d[i]);
        send_bit((^d) ^ par_flip);
        send_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        bus.DIN_EN = 1'b0;
        bus.DIN    = 1'b1;
        repeat (n) @(posedge K);
        #1;
    endtask

    task automatic prog_pulse();
        bus.PROG   = 1'b1;
        bus.DIN_EN = 1'b1;
        bus.DIN    = 1'b0;
        @(posedge K); #1;
        bus.PROG   = 1'b0;
        bus.DIN_EN = 1'b0;
    endtask

    localparam logic [CFG_W-1:0] FRAME_A = 37'h150008B038;
    localparam logic [CFG_W-1:0] FRAME_B = 37'h1FFFFFFFFF;
    localparam logic [CFG_W-1:0] FRAME_C = 37'h0000000001;
    localparam logic [CFG_W-1:0] FRAME_D = 37'h0ADEADBEEF;

    initial begin
        vec_t        vecs [3];
        int          base;
        logic [23:0] noise;

        vecs[0] = '{data: FRAME_A, idle: 0, exp_addr: 8'd0, exp_done: 1'b0};
        vecs[1] = '{data: FRAME_B, idle: 2, exp_addr: 8'd1, exp_done: 1'b0};
        vecs[2] = '{data: FRAME_D, idle: 5, exp_addr: 8'd2, exp_done: 1'b1};

        rst_n      = 1'b0;
        bus.PROG   = 1'b0;
        bus.DIN    = 1'b1;
        bus.DIN_EN = 1'b0;
        repeat (2) @(posedge K);
        #1;

        // Reset state
        check("rst_cfg_data", 64'(bus.cfg_data), 64'h0);
        check("rst_cfg_addr", 64'(bus.cfg_addr), 64'h0);
        check("rst_cfg_we",   64'(bus.cfg_we),   64'h0);
        check("rst_busy",     64'(bus.busy),     64'h0);
        check("rst_done",     64'(bus.done),     64'h0);
        check("rst_err",      64'(bus.err),      64'h0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Single frame load
        base = wr_q.size();
        send_byte(8'hF2);
        check("t1_busy_lock", 64'(bus.busy), 64'h1);
        send_byte(8'h01);
        send_frame(FRAME_A, 0, 1'b0, 1'b1);
        idle_cycles(3);
        check("t1_nwr", 64'(wr_q.size() - base), 64'd1);
        if (wr_q.size() > base) begin
            check("t1_addr",      64'(wr_q[base].addr), 64'h0);
            check("t1_data",      64'(wr_q[base].data), 64'(FRAME_A));
            check("t1_done_at_we", 64'(wr_q[base].done), 64'h1);
            check("t1_busy_at_we", 64'(wr_q[base].busy), 64'h0);
        end
        check("t1_done", 64'(bus.done), 64'h1);
        check("t1_err",  64'(bus.err),  64'h0);
        check("t1_busy", 64'(bus.busy), 64'h0);

        // PROG clears status, keeps the last written word
        prog_pulse();
        check("prog_done", 64'(bus.done), 64'h0);
        check("prog_data_kept", 64'(bus.cfg_data), 64'(FRAME_A));

        // Three frames, varying idle gaps, DIN_EN toggling
        base    = wr_q.size();
        en_mode = 1;
        send_byte(8'hF2);
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) send_frame(vecs[i].data, vecs[i].idle, 1'b0, 1'b1);
        en_mode = 0;
        idle_cycles(3);
        check("t2_nwr", 64'(wr_q.size() - base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (wr_q.size() > base + i) begin
                check($sformatf("t2_addr%0d", i), 64'(wr_q[base+i].addr), 64'(vecs[i].exp_addr));
                check($sformatf("t2_data%0d", i), 64'(wr_q[base+i].data), 64'(vecs[i].data));
                check($sformatf("t2_done%0d", i), 64'(wr_q[base+i].done), 64'(vecs[i].exp_done));
            end
        end
        check("t2_done", 64'(bus.done), 64'h1);

        // Parity error on the second frame
        prog_pulse();
        base = wr_q.size();
        send_byte(8'hF2);
        send_byte(8'h02);
        send_frame(FRAME_C, 1, 1'b0, 1'b1);
        send_frame(FRAME_B, 0, 1'b1, 1'b1);
        idle_cycles(3);
        check("t3_nwr", 64'(wr_q.size() - base), 64'd1);
        check("t3_err",  64'(bus.err),  64'h1);
        check("t3_done", 64'(bus.done), 64'h0);
        check("t3_busy", 64'(bus.busy), 64'h0);
        check("t3_data_kept", 64'(bus.cfg_data), 64'(FRAME_C));
        // ERROR is absorbing: a complete good stream is ignored
        send_byte(8'hF2);
        send_byte(8'h01);
        send_frame(FRAME_D, 0, 1'b0, 1'b1);
        idle_cycles(3);
        check("t3_absorb_nwr", 64'(wr_q.size() - base), 64'd1);
        check("t3_absorb_err", 64'(bus.err), 64'h1);

        // Bad stop bit, then PROG and a good load
        prog_pulse();
        base = wr_q.size();
        send_byte(8'hF2);
        send_byte(8'h01);
        send_frame(FRAME_D, 0, 1'b0, 1'b0);
        idle_cycles(3);
        check("t4_nwr", 64'(wr_q.size() - base), 64'd0);
        check("t4_err", 64'(bus.err), 64'h1);
        prog_pulse();
        check("t4_prog_err", 64'(bus.err), 64'h0);
        send_byte(8'hF2);
        send_byte(8'h01);
        send_frame(FRAME_B, 3, 1'b0, 1'b1);
        idle_cycles(3);
        check("t4_nwr2", 64'(wr_q.size() - base), 64'd1);
        if (wr_q.size() > base) check("t4_data", 64'(wr_q[base].data), 64'(FRAME_B));
        check("t4_done", 64'(bus.done), 64'h1);
        check("t4_err2", 64'(bus.err),  64'h0);

        // Near-miss noise, then preamble and N=0
        prog_pulse();
        base  = wr_q.size();
        noise = 24'b0111_0010_1111_0011_1111_0110;
        for (int i = 23; i >= 0; i--) send_bit(noise[i]);
        check("t5_noise_busy", 64'(bus.busy), 64'h0);
        check("t5_noise_err",  64'(bus.err),  64'h0);
        send_byte(8'hF2);
        check("t5_lock_busy", 64'(bus.busy), 64'h1);
        send_byte(8'h00);
        idle_cycles(3);
        check("t5_err",  64'(bus.err),  64'h1);
        check("t5_busy", 64'(bus.busy), 64'h0);
        check("t5_nwr",  64'(wr_q.size() - base), 64'd0);

        // Reset in the middle of DATA
        prog_pulse();
        base = wr_q.size();
        send_byte(8'hF2);
        send_byte(8'h01);
        send_bit(1'b0);
        for (int i = CFG_W - 1; i >= CFG_W - 10; i--) send_bit(FRAME_D[i]);
        check("t6_busy_mid", 64'(bus.busy), 64'h1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_data", 64'(bus.cfg_data), 64'h0);
        check("t6_rst_addr", 64'(bus.cfg_addr), 64'h0);
        check("t6_rst_busy", 64'(bus.busy),     64'h0);
        check("t6_rst_err",  64'(bus.err),      64'h0);
        check("t6_rst_done", 64'(bus.done),     64'h0);
        bus.DIN_EN = 1'b0;
        @(posedge K); #1;
        rst_n = 1'b1;
        idle_cycles(50);
        check("t6_nwr_after_rst", 64'(wr_q.size() - base), 64'd0);
        send_byte(8'hF2);
        send_byte(8'h01);
        send_frame(FRAME_D, 1, 1'b0, 1'b1);
        idle_cycles(3);
        check("t6_nwr", 64'(wr_q.size() - base), 64'd1);
        if (wr_q.size() > base) begin
            check("t6_addr", 64'(wr_q[base].addr), 64'h0);
            check("t6_data", 64'(wr_q[base].data), 64'(FRAME_D));
        end
        check("t6_done", 64'(bus.done), 64'h1);

        check("we_single_cycle", 64'(we_double), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
